// File: rtl/neuron_stream.sv
// ---------------------------------------------------------------------------
// neuron_stream
//
// Signed multiply-accumulate neuron fed by a valid/ready stream. One run
// accumulates M input/weight products and adds a bias captured at start.
// The sum is then saturated to N bits and registered together with a result
// flag and an overflow flag.
//
// Optional feature macro: NEURON_STREAM_RELU_EN
//   When defined, a ReLU is applied after saturation, so any negative result
//   becomes 0. ovf still reports a negative saturation.
//
// Ports:
//   clk       single clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   start     begin a run (only looked at while idle)
//   bias      signed bias, captured when start is accepted
//   in_valid  an in/weight pair is offered this cycle
//   in_ready  block accepts a pair this cycle (high while accumulating)
//   in        signed input operand
//   weight    signed weight operand
//   out       signed saturated result, held until the next result
//   ready     result valid, stays high until the next accepted start
//   busy      run in progress
//   ovf       last result was saturated
// ---------------------------------------------------------------------------
module neuron_stream #(
    parameter int DW = 8,
    parameter int WW = 8,
    parameter int M  = 4,
    parameter int N  = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [N-1:0]  bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in,
    input  logic signed [WW-1:0] weight,
    output logic signed [N-1:0]  out,
    output logic                 ready,
    output logic                 busy,
    output logic                 ovf
);

    // Product, accumulator and compare widths. The accumulator carries
    // clog2(M)+1 guard bits so M worst-case products cannot wrap, and the
    // sum gets one more bit than the wider of accumulator and bias.
    localparam int PW = DW + WW;
    localparam int AW = PW + $clog2(M) + 1;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam int SW = ((AW > N) ? AW : N) + 1;

    localparam logic signed [SW-1:0] SAT_MAX = $signed({{(SW-N+1){1'b0}}, {(N-1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = $signed({{(SW-N+1){1'b1}}, {(N-1){1'b0}}});

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        FIN
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [AW-1:0] acc;
    logic        [CW-1:0] cnt;
    logic signed [N-1:0]  bias_reg;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;
    logic signed [SW-1:0] sum;
    logic signed [N-1:0]  sat_val;
    logic signed [N-1:0]  res_val;
    logic                 sat_hit;
    logic                 accept;
    logic                 last_pair;

    assign in_ready  = (state == ACC);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_pair = (cnt == CW'(M - 1));

    // Operands are sign-extended to the full product width before the
    // multiply so the product is exact.
    assign prod     = $signed({{WW{in[DW-1]}}, in}) * $signed({{DW{weight[WW-1]}}, weight});
    assign prod_ext = $signed({{(AW-PW){prod[PW-1]}}, prod});
    assign sum      = $signed({{(SW-AW){acc[AW-1]}}, acc})
                    + $signed({{(SW-N){bias_reg[N-1]}}, bias_reg});

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a start while idle opens a run, the M-th accepted
    // pair closes accumulation, and the finish state lasts exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ACC;
                end
            end
            ACC: begin
                if (accept && last_pair) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Saturation to N bits, followed by the optional ReLU. The clamp and
    // the overflow flag are decided on the wide sum so no wrap can hide an
    // overflow.
    always_comb begin
        sat_val = sum[N-1:0];
        sat_hit = 1'b0;
        if (sum > SAT_MAX) begin
            sat_val = {1'b0, {(N-1){1'b1}}};
            sat_hit = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_val = {1'b1, {(N-1){1'b0}}};
            sat_hit = 1'b1;
        end
        res_val = sat_val;
`ifdef NEURON_STREAM_RELU_EN
        if (sat_val[N-1]) begin
            res_val = '0;
        end
`else
        res_val = sat_val;
`endif
    end

    // Datapath registers. Starting a run clears the result flags but keeps
    // the previous out value, which only changes in the finish state.
    // Stalled cycles in ACC leave the accumulator and counter untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            bias_reg <= '0;
            out      <= '0;
            ready    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bias_reg <= bias;
                        acc      <= '0;
                        cnt      <= '0;
                        ready    <= 1'b0;
                        ovf      <= 1'b0;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + CW'(1);
                    end
                end
                FIN: begin
                    out   <= res_val;
                    ovf   <= sat_hit;
                    ready <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_stream.sv
// ---------------------------------------------------------------------------
// tb_neuron_stream
//
// Directed bench for neuron_stream. Instance dut_a uses the default
// parameters (N=18); instance dut_b uses N=16 for the saturation cases.
// Both instances share the pair stream, in_valid and reset, and each has its
// own start and bias. Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_neuron_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid;
    logic signed [7:0]  in_d;
    logic signed [7:0]  weight_d;

    logic               start_a;
    logic signed [17:0] bias_a;
    logic               in_ready_a;
    logic signed [17:0] out_a;
    logic               ready_a;
    logic               busy_a;
    logic               ovf_a;

    logic               start_b;
    logic signed [15:0] bias_b;
    logic               in_ready_b;
    logic signed [15:0] out_b;
    logic               ready_b;
    logic               busy_b;
    logic               ovf_b;

    int vectors     = 0;
    int miscompares = 0;

    int pair_in [4];
    int pair_wt [4];

    bit sel_b;
    int v_out;
    int v_ready;
    int v_busy;
    int v_ovf;
    int v_in_ready;

    neuron_stream dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .bias     (bias_a),
        .in_valid (in_valid),
        .in_ready (in_ready_a),
        .in       (in_d),
        .weight   (weight_d),
        .out      (out_a),
        .ready    (ready_a),
        .busy     (busy_a),
        .ovf      (ovf_a)
    );

    neuron_stream #(.DW(8), .WW(8), .M(4), .N(16)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .bias     (bias_b),
        .in_valid (in_valid),
        .in_ready (in_ready_b),
        .in       (in_d),
        .weight   (weight_d),
        .out      (out_b),
        .ready    (ready_b),
        .busy     (busy_b),
        .ovf      (ovf_b)
    );

    // View of whichever instance the current run targets.
    always_comb begin
        v_out      = sel_b ? int'(out_b) : int'(out_a);
        v_ready    = sel_b ? int'(ready_b) : int'(ready_a);
        v_busy     = sel_b ? int'(busy_b) : int'(busy_a);
        v_ovf      = sel_b ? int'(ovf_b) : int'(ovf_a);
        v_in_ready = sel_b ? int'(in_ready_b) : int'(in_ready_a);
    end

    // Single comparison point: counts the vector and reports a miscompare.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic setPairs(input int i0, input int w0, input int i1, input int w1,
                            input int i2, input int w2, input int i3, input int w3);
        pair_in[0] = i0; pair_wt[0] = w0;
        pair_in[1] = i1; pair_wt[1] = w1;
        pair_in[2] = i2; pair_wt[2] = w2;
        pair_in[3] = i3; pair_wt[3] = w3;
    endtask

    // One complete run on the selected instance, entered and left #1 after a
    // rising edge. Returns the number of edges from E0 to the edge that
    // raised ready. Optionally stalls every other cycle and pulses start
    // while accumulating.
    task automatic applyStimulus(input bit use_b, input int bias_v, input bit gapped,
                                 input bit pulse_start, output int cycles);
        int idx;
        int cyc;
        sel_b = use_b;
        if (use_b) begin
            bias_b  = 16'(bias_v);
            start_b = 1'b1;
        end else begin
            bias_a  = 18'(bias_v);
            start_a = 1'b1;
        end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        checkOutput("busy_E0", v_busy, 1);
        checkOutput("in_ready_E0", v_in_ready, 1);
        checkOutput("ready_clr_E0", v_ready, 0);
        checkOutput("ovf_clr_E0", v_ovf, 0);
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            in_valid = !gapped || (cyc % 2 == 0);
            in_d     = 8'(pair_in[idx]);
            weight_d = 8'(pair_wt[idx]);
            if (pulse_start && cyc == 1) begin
                if (use_b) start_b = 1'b1;
                else       start_a = 1'b1;
            end
            checkOutput("in_ready_acc", v_in_ready, 1);
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            if (in_valid) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        if (idx < 4) checkOutput("acc_timeout", idx, 4);
        checkOutput("in_ready_fin", v_in_ready, 0);
        checkOutput("busy_fin", v_busy, 1);
        checkOutput("ready_fin", v_ready, 0);
        @(posedge clk); #1;
        cycles = cyc + 1;
        checkOutput("busy_done", v_busy, 0);
    endtask

    int lat;
    int exp_neg;
    int exp_bias;
    int exp_sat_lo;

    initial begin
`ifdef NEURON_STREAM_RELU_EN
        exp_neg    = 0;
        exp_bias   = 0;
        exp_sat_lo = 0;
`else
        exp_neg    = -65024;
        exp_bias   = -30;
        exp_sat_lo = -32768;
`endif
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        bias_a   = '0;
        bias_b   = '0;
        in_valid = 1'b0;
        in_d     = '0;
        weight_d = '0;
        sel_b    = 1'b0;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_out_a", int'(out_a), 0);
        checkOutput("rst_ready_a", int'(ready_a), 0);
        checkOutput("rst_busy_a", int'(busy_a), 0);
        checkOutput("rst_ovf_a", int'(ovf_a), 0);
        checkOutput("rst_in_ready_a", int'(in_ready_a), 0);
        checkOutput("rst_out_b", int'(out_b), 0);
        checkOutput("rst_in_ready_b", int'(in_ready_b), 0);

        // Continuous valid: 18+4+78+70 = 170, ready on E5.
        setPairs(3, 6, 2, 2, 3, 26, 7, 10);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, lat);
        checkOutput("cont_latency", lat, 5);
        checkOutput("cont_out", v_out, 170);
        checkOutput("cont_ready", v_ready, 1);
        checkOutput("cont_ovf", v_ovf, 0);
        checkOutput("b_idle_during_a", int'(busy_b), 0);

        // ready is a level and out is held while idle.
        @(posedge clk); #1;
        checkOutput("hold_ready", v_ready, 1);
        checkOutput("hold_out", v_out, 170);

        // Gapped valid: stalls every other cycle, result on E8.
        applyStimulus(1'b0, 0, 1'b1, 1'b0, lat);
        checkOutput("gap_latency", lat, 8);
        checkOutput("gap_out", v_out, 170);
        checkOutput("gap_ready", v_ready, 1);

        // Negative sum: 4 * (-128*127) = -65024, inside 18-bit range.
        setPairs(-128, 127, -128, 127, -128, 127, -128, 127);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, lat);
        checkOutput("neg_out", v_out, exp_neg);
        checkOutput("neg_ovf", v_ovf, 0);

        // Bias: 170 - 200 = -30.
        setPairs(3, 6, 2, 2, 3, 26, 7, 10);
        applyStimulus(1'b0, -200, 1'b0, 1'b0, lat);
        checkOutput("bias_out", v_out, exp_bias);
        checkOutput("bias_ovf", v_ovf, 0);

        // Positive saturation on N=16: 4 * 127*127 = 64516.
        setPairs(127, 127, 127, 127, 127, 127, 127, 127);
        applyStimulus(1'b1, 0, 1'b0, 1'b0, lat);
        checkOutput("satp_out", v_out, 32767);
        checkOutput("satp_ovf", v_ovf, 1);
        checkOutput("a_idle_during_b", int'(busy_a), 0);

        // Negative saturation on N=16: -65024 - 10000 = -75024.
        setPairs(-128, 127, -128, 127, -128, 127, -128, 127);
        applyStimulus(1'b1, -10000, 1'b0, 1'b0, lat);
        checkOutput("satn_out", v_out, exp_sat_lo);
        checkOutput("satn_ovf", v_ovf, 1);

        // Abort after two accepted pairs, then a clean run with a stray
        // start pulse inside ACC.
        sel_b = 1'b0;
        setPairs(3, 6, 2, 2, 3, 26, 7, 10);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a  = 1'b0;
        in_valid = 1'b1;
        in_d     = 8'sd3;
        weight_d = 8'sd6;
        @(posedge clk); #1;
        in_d     = 8'sd2;
        weight_d = 8'sd2;
        @(posedge clk); #1;
        rst      = 1'b1;
        in_d     = 8'sd3;
        weight_d = 8'sd26;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort_ready", v_ready, 0);
        checkOutput("abort_busy", v_busy, 0);
        checkOutput("abort_in_ready", v_in_ready, 0);
        checkOutput("abort_out", v_out, 0);
        @(posedge clk); #1;
        checkOutput("abort_ready_hold", v_ready, 0);

        applyStimulus(1'b0, 0, 1'b0, 1'b1, lat);
        checkOutput("rerun_latency", lat, 5);
        checkOutput("rerun_out", v_out, 170);
        checkOutput("rerun_ovf", v_ovf, 0);
        checkOutput("rerun_ready", v_ready, 1);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
